// File: rtl/mips_ext_pkg.sv
// mips_ext_pkg
//   Shared types and helpers for the load-extend datapath.
//   ext_size_e : access size code carried on in_size (BYTE/HALF/WORD/DWORD).
//   size_bytes : number of bytes an access of a given size covers.
package mips_ext_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } ext_size_e;

  // Bytes covered by one access of the given size (1/2/4/8).
  function automatic int unsigned size_bytes(input ext_size_e sz);
    int unsigned n;
    case (sz)
      SZ_BYTE:  n = 1;
      SZ_HALF:  n = 2;
      SZ_WORD:  n = 4;
      default:  n = 8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ext_lane_select.sv
// ext_lane_select
//   Combinational lane picker and extender. Selects the addressed
//   byte/half/word/dword from a raw memory word and sign- or zero-extends
//   it to DATA_W.
//   Ports:
//     data      in   DATA_W  raw memory word
//     offset    in   OFF_W   byte offset inside the word
//     size      in   2       ext_size_e access size
//     is_signed in   1       1 = sign-extend, 0 = zero-extend
//     ext       out  DATA_W  extended result (0 whenever err is set)
//     err       out  1       illegal access
//   Configuration macro: LOAD_EXTEND_MISALIGN_TRAP_EN
//     defined   -> misaligned offsets raise err instead of being aligned.
//     undefined -> misaligned offsets are silently forced to natural alignment.
module ext_lane_select
  import mips_ext_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int BIG_ENDIAN = 0,
  localparam int NBYTES    = DATA_W / 8,
  localparam int OFF_W     = $clog2(NBYTES)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [OFF_W-1:0]  offset,
  input  logic [1:0]        size,
  input  logic              is_signed,
  output logic [DATA_W-1:0] ext,
  output logic              err
);

  localparam logic [DATA_W-1:0] ONES = '1;

  ext_size_e         sz;
  int unsigned       wbytes;
  logic [3:0]        wmask;
  logic [3:0]        offset_ext;
  logic              misaligned;
  logic              illegal;
  logic [OFF_W-1:0]  eff_off;
  int                start_i;
  logic [OFF_W-1:0]  start;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] field;
  logic              sign;

  assign sz = ext_size_e'(size);

  // Lane selection and extension. The field is shifted down to bit 0 and
  // masked to W bits; the field MSB is the top set bit of that mask. A
  // full-width field leaves ~mask empty, so is_signed has no effect there.
  always_comb begin
    wbytes     = size_bytes(sz);
    wmask      = 4'(wbytes - 1);
    offset_ext = 4'(offset);
    misaligned = |(offset_ext & wmask);
    illegal    = (sz == SZ_DWORD) && (DATA_W == 32);
    eff_off    = offset & ~wmask[OFF_W-1:0];

    // Big-endian lanes count from the top of the word.
    if (BIG_ENDIAN != 0) begin
      start_i = NBYTES - int'(wbytes) - int'(eff_off);
    end else begin
      start_i = int'(eff_off);
    end
    if (illegal || (start_i < 0)) begin
      start_i = 0;
    end
    start = OFF_W'(start_i);

    shifted = data >> {start, 3'b000};
    mask    = ~(ONES << (8 * wbytes));
    field   = shifted & mask;
    sign    = is_signed && (|(field & ~(mask >> 1)));
    ext     = field | (sign ? ~mask : '0);

`ifdef LOAD_EXTEND_MISALIGN_TRAP_EN
    err = illegal || misaligned;
`else
    err = illegal;
`endif

    if (err) begin
      ext = '0;
    end
  end

endmodule

// File: rtl/load_extend_unit.sv
// load_extend_unit
//   Registered load-data extractor/extender between the data-memory read
//   port and register-file writeback. One valid/ready register slice with
//   one cycle latency and full throughput; a destination tag rides along.
//   Ports:
//     clk        in   1       rising-edge clock
//     reset      in   1       synchronous active-high reset
//     in_valid   in   1       input transfer valid
//     in_ready   out  1       unit can accept input this cycle
//     in_data    in   DATA_W  raw memory word
//     in_offset  in   OFF_W   byte offset within the word
//     in_size    in   2       ext_size_e access size
//     in_signed  in   1       1 = sign-extend, 0 = zero-extend
//     in_tag     in   TAG_W   pass-through tag
//     out_valid  out  1       output register holds a result
//     out_ready  in   1       consumer accepts the output this cycle
//     out_data   out  DATA_W  extended result
//     out_tag    out  TAG_W   tag of the result
//     out_err    out  1       access error
//   Configuration macro: LOAD_EXTEND_MISALIGN_TRAP_EN (see ext_lane_select).
module load_extend_unit
  import mips_ext_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 5,
  parameter int BIG_ENDIAN = 0,
  localparam int NBYTES    = DATA_W / 8,
  localparam int OFF_W     = $clog2(NBYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  logic [DATA_W-1:0] lane_ext;
  logic              lane_err;
  logic              accept;

  ext_lane_select #(
    .DATA_W     (DATA_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane (
    .data      (in_data),
    .offset    (in_offset),
    .size      (in_size),
    .is_signed (in_signed),
    .ext       (lane_ext),
    .err       (lane_err)
  );

  // The slice can take a new item when empty or when the held one drains
  // this same cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register slice. Payload only changes on accept, so a stalled or
  // drained result stays stable on out_data/out_tag/out_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= lane_ext;
      out_tag   <= in_tag;
      out_err   <= lane_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_load_extend_unit.sv
// tb_load_extend_unit
//   Self-checking bench for load_extend_unit (DATA_W=32). A little-endian
//   and a big-endian instance share the same inputs; directed vectors with
//   hand-computed results plus sequences for throughput, stall and reset.
//   Expectations for misaligned accesses follow LOAD_EXTEND_MISALIGN_TRAP_EN.
module tb_load_extend_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  in_offset;
  logic [1:0]  in_size;
  logic        in_signed;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        le_in_ready, le_out_valid, le_out_err;
  logic [31:0] le_out_data;
  logic [4:0]  le_out_tag;
  logic        be_in_ready, be_out_valid, be_out_err;
  logic [31:0] be_out_data;
  logic [4:0]  be_out_tag;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] expLe;
    logic [31:0] expBe;
    logic        expErr;
  } vec_t;

  vec_t vecs[12];

  load_extend_unit #(.DATA_W(32), .TAG_W(5), .BIG_ENDIAN(0)) u_le (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (le_in_ready),
    .in_data   (in_data),
    .in_offset (in_offset),
    .in_size   (in_size),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (le_out_valid),
    .out_ready (out_ready),
    .out_data  (le_out_data),
    .out_tag   (le_out_tag),
    .out_err   (le_out_err)
  );

  load_extend_unit #(.DATA_W(32), .TAG_W(5), .BIG_ENDIAN(1)) u_be (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (be_in_ready),
    .in_data   (in_data),
    .in_offset (in_offset),
    .in_size   (in_size),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (be_out_valid),
    .out_ready (out_ready),
    .out_data  (be_out_data),
    .out_tag   (be_out_tag),
    .out_err   (be_out_err)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Hard time limit so the run always ends even if the bench logic stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one transfer at a falling edge, hold it across one rising edge,
  // then drop in_valid; the result is registered at that edge.
  task automatic applyStimulus(input vec_t v, input logic [4:0] tag);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = v.data;
    in_offset = v.off;
    in_size   = v.size;
    in_signed = v.sgn;
    in_tag    = tag;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  initial begin
    logic [31:0] heldData;
    logic [31:0] byteExp[4];

    // Vectors on 32'h8899_AABB unless noted: LE bytes BB,AA,99,88 from byte 0.
    vecs[0]  = '{32'h8899_AABB, 2'd1, 2'd0, 1'b1, 32'hFFFF_FFAA, 32'hFFFF_FF99, 1'b0};
    vecs[1]  = '{32'h8899_AABB, 2'd1, 2'd0, 1'b0, 32'h0000_00AA, 32'h0000_0099, 1'b0};
    vecs[2]  = '{32'h8899_AABB, 2'd2, 2'd1, 1'b1, 32'hFFFF_8899, 32'hFFFF_AABB, 1'b0};
    vecs[3]  = '{32'h8899_AABB, 2'd2, 2'd1, 1'b0, 32'h0000_8899, 32'h0000_AABB, 1'b0};
    vecs[4]  = '{32'h8899_AABB, 2'd0, 2'd2, 1'b1, 32'h8899_AABB, 32'h8899_AABB, 1'b0};
    vecs[5]  = '{32'h8899_AABB, 2'd3, 2'd0, 1'b1, 32'hFFFF_FF88, 32'hFFFF_FFBB, 1'b0};
    vecs[6]  = '{32'h0000_007F, 2'd0, 2'd0, 1'b1, 32'h0000_007F, 32'h0000_0000, 1'b0};
    vecs[7]  = '{32'h1234_8000, 2'd0, 2'd1, 1'b1, 32'hFFFF_8000, 32'h0000_1234, 1'b0};
`ifdef LOAD_EXTEND_MISALIGN_TRAP_EN
    vecs[8]  = '{32'h8899_AABB, 2'd1, 2'd1, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[9]  = '{32'h8899_AABB, 2'd2, 2'd2, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1};
`else
    vecs[8]  = '{32'h8899_AABB, 2'd1, 2'd1, 1'b1, 32'hFFFF_AABB, 32'hFFFF_8899, 1'b0};
    vecs[9]  = '{32'h8899_AABB, 2'd2, 2'd2, 1'b0, 32'h8899_AABB, 32'h8899_AABB, 1'b0};
`endif
    vecs[10] = '{32'h8899_AABB, 2'd0, 2'd3, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[11] = '{32'hFFFF_FFFF, 2'd2, 2'd0, 1'b0, 32'h0000_00FF, 32'h0000_00FF, 1'b0};

    byteExp[0] = 32'h0000_00BB;
    byteExp[1] = 32'h0000_00AA;
    byteExp[2] = 32'h0000_0099;
    byteExp[3] = 32'h0000_0088;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_offset = '0;
    in_size   = '0;
    in_signed = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_valid", 64'(le_out_valid), 64'd0);
    checkOutput("reset_data", 64'(le_out_data), 64'd0);
    checkOutput("reset_tag", 64'(le_out_tag), 64'd0);
    checkOutput("reset_err", 64'(le_out_err), 64'd0);
    checkOutput("reset_ready", 64'(le_in_ready), 64'd1);

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], 5'(i + 8));
      checkOutput($sformatf("vec%0d_valid", i), 64'(le_out_valid), 64'd1);
      checkOutput($sformatf("vec%0d_le_data", i), 64'(le_out_data), 64'(vecs[i].expLe));
      checkOutput($sformatf("vec%0d_be_data", i), 64'(be_out_data), 64'(vecs[i].expBe));
      checkOutput($sformatf("vec%0d_err", i), 64'(le_out_err), 64'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d_tag", i), 64'(le_out_tag), 64'(i + 8));
    end

    // Back-to-back: four unsigned byte loads, results on consecutive cycles.
    @(negedge clk);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        checkOutput($sformatf("b2b%0d_valid", k), 64'(le_out_valid), 64'd1);
        checkOutput($sformatf("b2b%0d_tag", k), 64'(le_out_tag), 64'(k));
        checkOutput($sformatf("b2b%0d_data", k), 64'(le_out_data), 64'(byteExp[k-1]));
      end
      if (k < 4) begin
        in_valid  = 1'b1;
        in_data   = 32'h8899_AABB;
        in_offset = 2'(k);
        in_size   = 2'd0;
        in_signed = 1'b0;
        in_tag    = 5'(k + 1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("b2b_drain_valid", 64'(le_out_valid), 64'd0);
    checkOutput("b2b_drain_tag", 64'(le_out_tag), 64'd4);

    // Stall: hold item tag 5 for three cycles while tag 6 waits.
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    in_offset = 2'd0;
    in_size   = 2'd2;
    in_signed = 1'b0;
    in_tag    = 5'd5;
    out_ready = 1'b0;
    @(negedge clk);
    heldData  = 32'h1234_5678;
    in_data   = 32'hCAFE_F00D;
    in_tag    = 5'd6;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("stall%0d_valid", c), 64'(le_out_valid), 64'd1);
      checkOutput($sformatf("stall%0d_in_ready", c), 64'(le_in_ready), 64'd0);
      checkOutput($sformatf("stall%0d_data", c), 64'(le_out_data), 64'(heldData));
      checkOutput($sformatf("stall%0d_tag", c), 64'(le_out_tag), 64'd5);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", 64'(le_in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("release_tag", 64'(le_out_tag), 64'd6);
    checkOutput("release_data", 64'(le_out_data), 64'hCAFE_F00D);
    checkOutput("release_valid", 64'(le_out_valid), 64'd1);
    @(negedge clk);
    checkOutput("release_drain_valid", 64'(le_out_valid), 64'd0);
    checkOutput("release_drain_data", 64'(le_out_data), 64'hCAFE_F00D);

    // Reset while a result is held under stall.
    in_valid  = 1'b1;
    in_data   = 32'h8899_AABB;
    in_offset = 2'd0;
    in_size   = 2'd3;
    in_signed = 1'b1;
    in_tag    = 5'd7;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("pre_reset_valid", 64'(le_out_valid), 64'd1);
    checkOutput("pre_reset_err", 64'(le_out_err), 64'd1);
    checkOutput("pre_reset_tag", 64'(le_out_tag), 64'd7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_reset_valid", 64'(le_out_valid), 64'd0);
    checkOutput("mid_reset_data", 64'(le_out_data), 64'd0);
    checkOutput("mid_reset_tag", 64'(le_out_tag), 64'd0);
    checkOutput("mid_reset_err", 64'(le_out_err), 64'd0);
    @(negedge clk);
    checkOutput("post_reset_valid", 64'(le_out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
